// File: rtl/tempsens_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tempsens_pkg : register map and shared types of the temperature sensor
// Rev 1.0
// ---------------------------------------------------------------------------
package tempsens_pkg;

   localparam int unsigned CONV_TIME_W = 4;

   localparam logic [7:0] TS_RESET_N_OFFSET   = 8'h04;
   localparam logic [7:0] TS_CONV_TIME_OFFSET = 8'h08;
   localparam logic [7:0] TS_EN_OFFSET        = 8'h0C;
   localparam logic [7:0] TS_DOUT_OFFSET      = 8'h14;
   localparam logic [7:0] TS_DONE_OFFSET      = 8'h18;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_D_ERROR = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_OPCODE  = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      STEP_RST_LO    = 3'd0,
      STEP_RST_HI    = 3'd1,
      STEP_CONV_TIME = 3'd2,
      STEP_EN        = 3'd3,
      STEP_POLL_DONE = 3'd4,
      STEP_READ_DOUT = 3'd5,
      STEP_DISABLE   = 3'd6
   } step_e;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlul_pkg : TL-UL channel structures and opcodes
// Rev 1.0
// ---------------------------------------------------------------------------
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tempsens_poll_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tempsens_poll_host : TL-UL initiator running one full sensor conversion
// Rev 1.0
// ---------------------------------------------------------------------------
module tempsens_poll_host
   import tlul_pkg::*;
   import tempsens_pkg::*;
#(
   parameter logic [31:0] BaseAddr  = 32'h0,
   parameter logic [15:0] PollLimit = 16'd1000,
   parameter logic [7:0]  SourceId  = 8'd0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [CONV_TIME_W-1:0] conv_time_i,
   output logic                   busy_o,
   output logic                   sample_valid_o,
   output logic [23:0]            sample_o,
   output logic                   err_o,
   output logic [1:0]             err_code_o,
   output tl_h2d_t                tl_o,
   input  tl_d2h_t                tl_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   logic [1:0]             r_state, w_state_d;
   step_e                  r_step, w_step_d;
   logic [CONV_TIME_W-1:0] r_conv_time, w_conv_time_d;
   logic [15:0]            r_poll_cnt, w_poll_cnt_d, w_poll_inc;
   logic [23:0]            r_result, w_result_d;
   logic [23:0]            r_sample, w_sample_d;
   logic                   r_abort, w_abort_d;
   err_code_e              r_err_code, w_err_code_d;
   logic                   r_sample_valid, w_sample_valid_d;
   logic                   r_err, w_err_d;
   logic                   w_is_read;
   err_code_e              w_rsp_err;
   logic [7:0]             w_offset;
   logic [31:0]            w_wdata;
   logic                   w_unused_tl;

   assign w_is_read = (r_step == STEP_POLL_DONE) || (r_step == STEP_READ_DOUT);
   assign w_poll_inc = r_poll_cnt + 16'd1;

   // d_error takes priority over an unexpected opcode
   always_comb begin
      w_rsp_err = ERR_NONE;
      if (tl_i.d_error) begin
         w_rsp_err = ERR_D_ERROR;
      end else if (tl_i.d_opcode != (w_is_read ? AccessAckData : AccessAck)) begin
         w_rsp_err = ERR_OPCODE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state        <= ST_IDLE;
         r_step         <= STEP_RST_LO;
         r_conv_time    <= '0;
         r_poll_cnt     <= '0;
         r_result       <= '0;
         r_sample       <= '0;
         r_abort        <= 1'b0;
         r_err_code     <= ERR_NONE;
         r_sample_valid <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_state        <= w_state_d;
         r_step         <= w_step_d;
         r_conv_time    <= w_conv_time_d;
         r_poll_cnt     <= w_poll_cnt_d;
         r_result       <= w_result_d;
         r_sample       <= w_sample_d;
         r_abort        <= w_abort_d;
         r_err_code     <= w_err_code_d;
         r_sample_valid <= w_sample_valid_d;
         r_err          <= w_err_d;
      end
   end

   always_comb begin
      w_state_d        = r_state;
      w_step_d         = r_step;
      w_conv_time_d    = r_conv_time;
      w_poll_cnt_d     = r_poll_cnt;
      w_result_d       = r_result;
      w_sample_d       = r_sample;
      w_abort_d        = r_abort;
      w_err_code_d     = r_err_code;
      w_sample_valid_d = 1'b0;
      w_err_d          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // the result-pulse cycle still counts as busy
            if (start_i && !r_sample_valid && !r_err) begin
               w_state_d     = ST_REQ;
               w_step_d      = STEP_RST_LO;
               w_conv_time_d = conv_time_i;
               w_poll_cnt_d  = '0;
               w_abort_d     = 1'b0;
               w_err_code_d  = ERR_NONE;
            end
         end
         ST_REQ: begin
            if (tl_i.a_ready) begin
               w_state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            if (tl_i.d_valid) begin
               if (r_step == STEP_DISABLE) begin
                  w_state_d = ST_IDLE;
                  if (r_abort) begin
                     w_err_d = 1'b1;
                  end else if (w_rsp_err != ERR_NONE) begin
                     w_err_code_d = w_rsp_err;
                     w_err_d      = 1'b1;
                  end else begin
                     w_sample_d       = r_result;
                     w_sample_valid_d = 1'b1;
                  end
               end else if (w_rsp_err != ERR_NONE) begin
                  w_state_d    = ST_REQ;
                  w_step_d     = STEP_DISABLE;
                  w_abort_d    = 1'b1;
                  w_err_code_d = w_rsp_err;
               end else begin
                  w_state_d = ST_REQ;
                  case (r_step)
                     STEP_POLL_DONE: begin
                        if (tl_i.d_data[0]) begin
                           w_step_d = STEP_READ_DOUT;
                        end else begin
                           w_poll_cnt_d = w_poll_inc;
                           if (w_poll_inc == PollLimit) begin
                              w_step_d     = STEP_DISABLE;
                              w_abort_d    = 1'b1;
                              w_err_code_d = ERR_TIMEOUT;
                           end
                        end
                     end
                     STEP_READ_DOUT: begin
                        w_result_d = tl_i.d_data[23:0];
                        w_step_d   = STEP_DISABLE;
                     end
                     default: begin
                        w_step_d = step_e'(r_step + 3'd1);
                     end
                  endcase
               end
            end
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_offset = TS_RESET_N_OFFSET;
      w_wdata  = '0;
      case (r_step)
         STEP_RST_LO:    w_offset = TS_RESET_N_OFFSET;
         STEP_RST_HI: begin
            w_offset = TS_RESET_N_OFFSET;
            w_wdata  = 32'd1;
         end
         STEP_CONV_TIME: begin
            w_offset = TS_CONV_TIME_OFFSET;
            w_wdata  = {{(32-CONV_TIME_W){1'b0}}, r_conv_time};
         end
         STEP_EN: begin
            w_offset = TS_EN_OFFSET;
            w_wdata  = 32'd1;
         end
         STEP_POLL_DONE: w_offset = TS_DONE_OFFSET;
         STEP_READ_DOUT: w_offset = TS_DOUT_OFFSET;
         STEP_DISABLE:   w_offset = TS_EN_OFFSET;
         default:        w_offset = TS_RESET_N_OFFSET;
      endcase

      tl_o           = '0;
      tl_o.a_valid   = (r_state == ST_REQ);
      tl_o.a_opcode  = w_is_read ? Get : PutFullData;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_source  = SourceId;
      tl_o.a_address = BaseAddr + {24'h0, w_offset};
      tl_o.a_data    = w_wdata;
      tl_o.d_ready   = (r_state == ST_RSP);
   end

   assign busy_o         = (r_state != ST_IDLE) || r_sample_valid || r_err;
   assign sample_valid_o = r_sample_valid;
   assign sample_o       = r_sample;
   assign err_o          = r_err;
   assign err_code_o     = r_err_code;

   assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                          tl_i.d_data[31:24]};

endmodule
`default_nettype wire

// File: tb/tb_tempsens_poll_host.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tempsens_poll_host : table-driven and random bench with a sensor responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tempsens_poll_host;
   import tlul_pkg::*;

   localparam logic [31:0] BASE       = 32'h4000_1000;
   localparam int          POLL_LIMIT = 4;
   localparam logic [7:0]  SRC        = 8'h05;

   typedef struct {
      logic [3:0]  ct;
      int          done_after;
      logic [23:0] dout;
      int          err_at;
      logic [1:0]  err_kind;
      int          stall_max;
      int          poke_at;
      logic        exp_ok;
      logic [1:0]  exp_code;
      int          exp_n;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  conv_time_i = 4'h0;
   logic        busy_o, sample_valid_o, err_o;
   logic [23:0] sample_o;
   logic [1:0]  err_code_o;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;

   tempsens_poll_host #(
      .BaseAddr (BASE),
      .PollLimit(16'(POLL_LIMIT)),
      .SourceId (SRC)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .conv_time_i   (conv_time_i),
      .busy_o        (busy_o),
      .sample_valid_o(sample_valid_o),
      .sample_o      (sample_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o),
      .tl_o          (tl_o),
      .tl_i          (tl_i)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   vec_t        cur;
   int          acc_idx = 0, done_cnt = 0, acc_base = 0, done_base = 0;
   logic [23:0] last_sample = '0;
   acc_t        exp_q[$];

   // ---------------- sensor adapter responder ----------------
   logic        outstanding, dv, de;
   tl_d_op_e    dop;
   logic [31:0] dd;
   int          stall_left;

   function automatic tl_d_op_e rsp_op(input logic is_read, input logic flip);
      if (is_read ^ flip) return AccessAckData;
      return AccessAck;
   endfunction

   function automatic logic [31:0] rsp_data(input logic [31:0] addr, input logic is_read,
                                            input int done_idx);
      if (!is_read) return 32'h0;
      if (addr == BASE + 32'h18) return {16'hBEE0, 15'h0, (done_idx >= cur.done_after)};
      if (addr == BASE + 32'h14) return {8'hC3, cur.dout};
      return 32'hDEAD_0000;
   endfunction

   always_comb begin
      tl_i          = '0;
      tl_i.a_ready  = !outstanding && (stall_left == 0);
      tl_i.d_valid  = dv;
      tl_i.d_opcode = dop;
      tl_i.d_data   = dd;
      tl_i.d_error  = de;
      tl_i.d_size   = 2'd2;
      tl_i.d_source = SRC;
   end

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= 1'b0;
         dv          <= 1'b0;
         de          <= 1'b0;
         dop         <= AccessAck;
         dd          <= '0;
         stall_left  <= 0;
      end else begin
         if (dv && tl_o.d_ready) begin
            dv          <= 1'b0;
            outstanding <= 1'b0;
         end
         if (tl_o.a_valid && tl_i.a_ready) begin
            outstanding <= 1'b1;
            dv          <= 1'b1;
            de          <= ((acc_idx - acc_base) == cur.err_at) && (cur.err_kind == 2'd1);
            dop         <= rsp_op(tl_o.a_opcode == Get,
                                  ((acc_idx - acc_base) == cur.err_at) && (cur.err_kind == 2'd3));
            dd          <= rsp_data(tl_o.a_address, tl_o.a_opcode == Get, done_cnt - done_base);
            acc_idx     <= acc_idx + 1;
            if (tl_o.a_opcode == Get && tl_o.a_address == BASE + 32'h18) done_cnt <= done_cnt + 1;
            stall_left  <= int'($urandom_range(32'(cur.stall_max), 0));
         end else if (tl_o.a_valid && !outstanding && stall_left > 0) begin
            stall_left <= stall_left - 1;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic acc_t mk(input logic wr, input logic [31:0] off, input logic [31:0] d);
      acc_t a;
      a.wr   = wr;
      a.addr = BASE + off;
      a.data = d;
      return a;
   endfunction

   function automatic void model(input vec_t s, output logic ok, output logic [1:0] code);
      acc_t full[$];
      int   zeros;
      logic tmo;
      full.push_back(mk(1'b1, 32'h04, 32'd0));
      full.push_back(mk(1'b1, 32'h04, 32'd1));
      full.push_back(mk(1'b1, 32'h08, {28'h0, s.ct}));
      full.push_back(mk(1'b1, 32'h0C, 32'd1));
      tmo   = (s.done_after >= POLL_LIMIT);
      zeros = tmo ? POLL_LIMIT : s.done_after;
      for (int k = 0; k < zeros; k++) full.push_back(mk(1'b0, 32'h18, 32'd0));
      if (!tmo) begin
         full.push_back(mk(1'b0, 32'h18, 32'd0));
         full.push_back(mk(1'b0, 32'h14, 32'd0));
      end
      full.push_back(mk(1'b1, 32'h0C, 32'd0));
      code = tmo ? 2'd2 : 2'd0;
      exp_q.delete();
      if (s.err_at >= 0 && s.err_at < full.size() - 1) begin
         for (int k = 0; k <= s.err_at; k++) exp_q.push_back(full[k]);
         exp_q.push_back(mk(1'b1, 32'h0C, 32'd0));
         code = s.err_kind;
      end else begin
         exp_q = full;
         if (s.err_at == full.size() - 1 && !tmo) code = s.err_kind;
      end
      ok = (code == 2'd0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- one conversion ----------------
   task automatic run_vec(input vec_t v, input string name, input logic e_ok,
                          input logic [1:0] e_code, input int e_n);
      acc_t    obs[$];
      acc_t    a;
      tl_h2d_t snap;
      logic    pend = 1'b0;
      logic    done = 1'b0;
      int      nvalid = 0, nerr = 0, viol = 0, lat = -1, tail = 0, bad_idx = -1;
      cur       = v;
      acc_base  = acc_idx;
      done_base = done_cnt;
      @(negedge clk_i);
      start_i     = 1'b1;
      conv_time_i = v.ct;
      @(negedge clk_i);
      for (int k = 1; k <= 600 && tail < 4; k++) begin
         if (k > 1) @(negedge clk_i);
         start_i     = (k == v.poke_at);
         conv_time_i = ~v.ct;
         if (k == 1 && !tl_o.a_valid) viol++;
         if (pend && (!tl_o.a_valid || tl_o.a_opcode != snap.a_opcode ||
                      tl_o.a_address != snap.a_address || tl_o.a_data != snap.a_data)) viol++;
         if (tl_o.a_valid && (tl_o.a_size != 2'd2 || tl_o.a_mask != 4'hF ||
                              tl_o.a_source != SRC || tl_o.a_param != 3'd0)) viol++;
         if (tl_o.a_valid && tl_o.a_opcode != Get && tl_o.a_opcode != PutFullData) viol++;
         if (tl_o.a_valid && tl_i.a_ready) begin
            a.wr   = (tl_o.a_opcode == PutFullData);
            a.addr = tl_o.a_address;
            a.data = tl_o.a_data;
            obs.push_back(a);
         end
         pend = tl_o.a_valid && !tl_i.a_ready;
         snap = tl_o;
         if (!done) begin
            if (!busy_o) viol++;
         end else begin
            if (busy_o || tl_o.a_valid) viol++;
            tail++;
         end
         if (sample_valid_o) nvalid++;
         if (err_o) nerr++;
         if ((sample_valid_o || err_o) && lat < 0) lat = k;
         if (sample_valid_o || err_o) done = 1'b1;
      end
      start_i = 1'b0;
      if (e_ok) last_sample = v.dout;
      chk({name, " finished"}, 32'(done), 32'd1);
      chk({name, " valid_pulses"}, nvalid, e_ok ? 1 : 0);
      chk({name, " err_pulses"}, nerr, e_ok ? 0 : 1);
      chk({name, " err_code"}, 32'(err_code_o), 32'(e_code));
      chk({name, " sample"}, 32'(sample_o), 32'(last_sample));
      chk({name, " n_access"}, obs.size(), e_n);
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
         if (bad_idx < 0 && (obs[i].wr != exp_q[i].wr || obs[i].addr != exp_q[i].addr ||
                             obs[i].data != exp_q[i].data)) bad_idx = i;
      chk({name, " first_bad_access"}, bad_idx, -1);
      chk({name, " protocol_viol"}, viol, 0);
      if (v.exp_lat > 0) chk({name, " latency"}, lat, v.exp_lat);
   endtask

   vec_t tbl[8];

   initial begin
      vec_t       v;
      logic       m_ok;
      logic [1:0] m_code;
      int         w;

      // ct, done_after, dout, err_at, kind, stall, poke, ok, code, n, lat
      tbl[0] = '{4'h5, 2,  24'hABCDEF, -1, 2'd0, 0, 0, 1'b1, 2'd0, 9, 0};
      tbl[1] = '{4'h5, 2,  24'hABCDEF, -1, 2'd0, 5, 0, 1'b1, 2'd0, 9, 0};
      tbl[2] = '{4'h9, 99, 24'h123456, -1, 2'd0, 0, 0, 1'b0, 2'd2, 9, 0};
      tbl[3] = '{4'h3, 0,  24'h654321, 2,  2'd1, 0, 0, 1'b0, 2'd1, 4, 0};
      tbl[4] = '{4'hA, 0,  24'h0F0F0F, 5,  2'd3, 2, 0, 1'b0, 2'd3, 7, 0};
      tbl[5] = '{4'h1, 0,  24'h777777, 6,  2'd1, 0, 0, 1'b0, 2'd1, 7, 0};
      tbl[6] = '{4'hC, 99, 24'h111111, 8,  2'd3, 0, 0, 1'b0, 2'd2, 9, 0};
      tbl[7] = '{4'hF, 0,  24'h000001, -1, 2'd0, 0, 6, 1'b1, 2'd0, 7, 15};
      cur = tbl[0];

      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst a_valid", 32'(tl_o.a_valid), 0);
      chk("rst d_ready", 32'(tl_o.d_ready), 0);
      chk("rst busy", 32'(busy_o), 0);
      chk("rst pulses", 32'({sample_valid_o, err_o}), 0);
      chk("rst sample", 32'(sample_o), 0);
      chk("rst err_code", 32'(err_code_o), 0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      for (int i = 0; i < 8; i++) begin
         model(tbl[i], m_ok, m_code);
         run_vec(tbl[i], $sformatf("vec%0d", i), tbl[i].exp_ok, tbl[i].exp_code, tbl[i].exp_n);
      end

      // reset while polling a stuck DONE
      v = '{4'h7, 99, 24'h222222, -1, 2'd0, 0, 0, 1'b0, 2'd0, 0, 0};
      cur = v;
      acc_base = acc_idx;
      done_base = done_cnt;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      w = 0;
      while ((acc_idx - acc_base) < 6 && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      chk("midreset reached_poll", 32'(w < 100), 1);
      rst_ni = 1'b0;
      #1;
      chk("midreset a_valid", 32'(tl_o.a_valid), 0);
      chk("midreset busy", 32'(busy_o), 0);
      chk("midreset sample", 32'(sample_o), 0);
      chk("midreset err_code", 32'(err_code_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      last_sample = '0;
      @(negedge clk_i);
      model(tbl[0], m_ok, m_code);
      run_vec(tbl[0], "after_reset", 1'b1, 2'd0, 9);

      for (int i = 0; i < 40; i++) begin
         v.ct         = 4'($urandom);
         v.done_after = int'($urandom_range(5, 0));
         v.dout       = 24'($urandom);
         v.err_at     = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(9, 0));
         v.err_kind   = ($urandom_range(1, 0) == 0) ? 2'd1 : 2'd3;
         v.stall_max  = int'($urandom_range(5, 0));
         v.poke_at    = 0;
         v.exp_lat    = 0;
         model(v, m_ok, m_code);
         v.exp_ok     = m_ok;
         v.exp_code   = m_code;
         v.exp_n      = exp_q.size();
         run_vec(v, $sformatf("rand%0d", i), m_ok, m_code, exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tempsens_poll_host.md
# tempsens_poll_host

TL-UL host (initiator) that drives the temperature-sensor register adapter through a full conversion: pulses the sensor counter reset, programs conversion time, enables, polls DONE, reads the 24-bit result, disables. Sits between a local control block (start/result strobes) and the TL-UL device port of the temperature-sensor adapter. Lets the sensor run autonomously without CPU involvement.

## Interface
Parameters:
- BaseAddr, 32'h0, TL-UL base address of the sensor adapter; register offsets are added to it.
- PollLimit, 16'd1000, max DONE reads returning 0 before timeout.
- SourceId, 0, value driven on a_source for every request.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request one conversion; sampled only in IDLE.
- conv_time_i  in  4  SEL_CONV_TIME value, latched on accepted start.
- busy_o  out  1  high from accepted start until sample_valid_o/err_o pulse cycle inclusive.
- sample_valid_o  out  1  one-cycle pulse, sample_o updated.
- sample_o  out  24  last good DOUT; held until next success.
- err_o  out  1  one-cycle pulse on aborted sequence.
- err_code_o  out  2  0 none, 1 d_error, 2 poll timeout, 3 bad d_opcode; held until next start.
- tl_o  out  tl_h2d_t  TL-UL request channel.
- tl_i  in  tl_d2h_t  TL-UL response channel.

## Operation
- Register offsets (word): RESET_N 0x04, SEL_CONV_TIME 0x08, EN 0x0C, DOUT 0x14, DONE 0x18.
- Step sequence after start: S0 write RESET_N=0; S1 write RESET_N=1; S2 write SEL_CONV_TIME=conv_time latched; S3 write EN=1; S4 read DONE (repeat while bit0=0); S5 read DOUT; S6 write EN=0; then result.
- FSM: IDLE -> REQ -> RSP -> (next step REQ | IDLE). Step index 3 bits.
- REQ: a_valid=1, a_opcode PutFullData (writes) or Get (reads), a_size=2, a_mask=4'hF, a_address=BaseAddr+offset, a_data zero-extended value (0 for reads), a_source=SourceId. Leave REQ on a_valid&a_ready.
- RSP: d_ready=1 only here. On d_valid: check d_error, then d_opcode (AccessAck for writes, AccessAckData for reads).
- S4: DONE bit0=1 -> S5; else poll_cnt++ and reissue S4; poll_cnt==PollLimit after increment -> timeout.
- S5: capture d_data[23:0] into result register (not sample_o until S6 completes).
- S6 success: sample_o<=result, sample_valid_o pulse, IDLE.
- Error in S0–S5 (codes 1/3) or timeout: record err_code, jump to S6 (EN=0) once; S6 response status ignored in abort mode; then err_o pulse, IDLE, sample_o unchanged. Error in S6 on normal path: err_o with code, sample_o unchanged.
- Exactly one outstanding transaction; a_valid never deasserted before a_ready; request fields stable while a_valid.
- start_i while busy ignored.

## Timing
- Reset: all outputs 0 (a_valid, d_ready, busy_o, pulses, sample_o, err_code_o); FSM IDLE; poll_cnt 0.
- start_i high in IDLE at edge N -> busy_o and a_valid high from N+1.
- Against the register adapter (a_ready=~outstanding, response next cycle) each access takes 2 cycles; minimum sequence with DONE on first poll: 7 accesses = 14 cycles, sample_valid_o at cycle N+15.
- d_valid in same cycle as a_ready is impossible by protocol; not handled.
- Reset mid-sequence: immediate return to IDLE, a_valid drops asynchronously; sensor state not restored.
- poll_cnt 16 bits, cleared on start; no wrap (timeout precedes).

## Structure
- tempsens_pkg: register offsets, err-code enum, step enum, conv-time width. Shared with the adapter.
- Single module; request mux (address/opcode/data from step) is an always_comb block, no sub-module.
- Uses tlul_pkg for tl_h2d_t/tl_d2h_t, opcodes.

## Test plan
- Normal: conv_time 4'h5, DONE=1 on 3rd poll, DOUT=24'hABCDEF -> 9 accesses in order with correct addresses/data, sample_o=24'hABCDEF, sample_valid_o 1 pulse, err_o 0.
- Back-pressure: a_ready held low random 0–5 cycles -> a_valid and request fields stable, same result.
- Timeout: PollLimit=4, DONE stuck 0 -> exactly 4 DONE reads, then EN=0 write, err_o pulse, err_code_o=2, sample_o unchanged.
- d_error on S2 -> next request is EN=0 write, err_code_o=1, no sample_valid_o.
- Wrong opcode (AccessAck on DOUT read) -> err_code_o=3; start_i during busy ignored; reset mid-poll -> all outputs 0, next start runs cleanly.
